// File: rtl/conv3x3_window_mac.sv
// conv3x3_window_mac: streaming 3x3 convolution MAC with weight store, FSM and protocol error flag
module conv3x3_window_mac #(
  parameter int IMG_W  = 226,
  parameter int IMG_H  = 226,
  parameter int DATA_W = 9,
  parameter int W_W    = 8,
  parameter int ACC_W  = 21
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      pix_valid,
  input  logic [9*DATA_W-1:0]       matrix,
  input  logic                      w_load,
  input  logic signed [W_W-1:0]     w_data,
  input  logic signed [15:0]        bias,
  input  logic                      relu_en,
  output logic signed [ACC_W-1:0]   result,
  output logic                      out_valid,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      err
);
  localparam int PW = DATA_W + W_W;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [1:0]              fl_q, fl_d;
  logic [3:0]              idx_q, idx_d;
  logic signed [W_W-1:0]   w_q [9];
  logic signed [W_W-1:0]   w_d [9];
  logic                    err_q, err_d;
  logic                    win_v_q, win_v_d;
  logic                    prod_v_q, prod_v_d;
  logic                    sum_v_q, sum_v_d;
  logic                    out_v_q, out_v_d;
  logic                    done_q, done_d;
  logic signed [PW-1:0]    prod_q [9];
  logic signed [PW-1:0]    prod_d [9];
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic signed [ACC_W-1:0] result_q, result_d;

  // Control: FSM, raster counters, weight writes, valid pipeline and error tracking
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    fl_d     = fl_q;
    idx_d    = idx_q;
    w_d      = w_q;
    err_d    = err_q;
    win_v_d  = 1'b0;
    done_d   = 1'b0;
    prod_v_d = win_v_q;
    sum_v_d  = prod_v_q;
    out_v_d  = sum_v_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        err_d   = 1'b0;
        idx_d   = '0;
        col_d   = '0;
        row_d   = '0;
      end else if (w_load) begin
        w_d[idx_q] = w_data;
        idx_d      = idx_q == 4'd8 ? 4'd0 : idx_q + 4'd1;
      end
    end else begin
      if (start || w_load) err_d = 1'b1;
      if (state_q == RUN) begin
        if (pix_valid) begin
          win_v_d = row_q >= RW'(2) && col_q >= CW'(2);
          col_d   = col_q == CW'(IMG_W-1) ? '0 : col_q + 1'b1;
          row_d   = col_q == CW'(IMG_W-1) ? row_q + 1'b1 : row_q;
          if (col_q == CW'(IMG_W-1) && row_q == RW'(IMG_H-1)) begin
            state_d = FLUSH;
            fl_d    = '0;
          end
        end else begin
          err_d    = 1'b1;
          state_d  = IDLE;
          prod_v_d = 1'b0;
          sum_v_d  = 1'b0;
          out_v_d  = 1'b0;
        end
      end else begin
        fl_d = fl_q + 2'd1;
        if (fl_q == 2'd2) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  // Datapath: per-tap products, bias-added sum, optional ReLU on the output stage
  always_comb begin
    for (int k = 0; k < 9; k++)
      prod_d[k] = PW'($signed(matrix[DATA_W*k +: DATA_W])) * PW'(w_q[k]);
    sum_d = ACC_W'(bias);
    for (int k = 0; k < 9; k++) sum_d = sum_d + ACC_W'(prod_q[k]);
    result_d = sum_v_q ? ((relu_en && sum_q[ACC_W-1]) ? '0 : sum_q) : result_q;
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      fl_q     <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      win_v_q  <= 1'b0;
      prod_v_q <= 1'b0;
      sum_v_q  <= 1'b0;
      out_v_q  <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      result_q <= '0;
      for (int k = 0; k < 9; k++) begin
        w_q[k]    <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      fl_q     <= fl_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      win_v_q  <= win_v_d;
      prod_v_q <= prod_v_d;
      sum_v_q  <= sum_v_d;
      out_v_q  <= out_v_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      w_q      <= w_d;
      prod_q   <= prod_d;
    end
  end

  assign result     = result_q;
  assign out_valid  = out_v_q;
  assign frame_done = done_q;
  assign busy       = state_q != IDLE;
  assign err        = err_q;
endmodule

// File: tb/tb_conv3x3_window_mac.sv
// tb_conv3x3_window_mac: directed checks of the 3x3 window MAC on a 5x5 frame
module tb_conv3x3_window_mac;
  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               pix_valid = 1'b0;
  logic [80:0]        matrix = '0;
  logic               w_load = 1'b0;
  logic signed [7:0]  w_data = '0;
  logic signed [15:0] bias = '0;
  logic               relu_en = 1'b0;
  logic signed [20:0] result;
  logic               out_valid, frame_done, busy, err;

  int n_tests = 0;
  int n_fail = 0;
  int img [25];
  int got [$];
  int ndone = 0;
  int done_at = -1;

  conv3x3_window_mac #(.IMG_W(5), .IMG_H(5), .DATA_W(9), .W_W(8), .ACC_W(21)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .matrix(matrix),
    .w_load(w_load), .w_data(w_data), .bias(bias), .relu_en(relu_en), .result(result),
    .out_valid(out_valid), .frame_done(frame_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Collect results and frame_done on the falling edge
  always @(negedge clk) begin
    if (out_valid) got.push_back(int'($signed(result)));
    if (frame_done) begin
      ndone++;
      done_at = got.size();
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [80:0] win(input int idx);
    logic [80:0] m = '0;
    int r = idx / 5;
    int c = idx % 5;
    if (r >= 2 && c >= 2)
      for (int k = 0; k < 9; k++) m[9*k +: 9] = 9'(img[(r-2+k/3)*5 + (c-2+k%3)]);
    return m;
  endfunction

  task automatic load_w(input int w [9]);
    for (int k = 0; k < 9; k++) begin
      w_load = 1'b1;
      w_data = 8'(w[k]);
      step();
    end
    w_load = 1'b0;
  endtask

  task automatic run_frame(input int drop_at, input int wl_at, input int st_at, input bit rst_flush);
    int n_before;
    got.delete();
    ndone = 0;
    done_at = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("err_clr_on_start", int'(err), 0);
    for (int i = 0; i < 25; i++) begin
      if (i == 5) check("busy_run", int'(busy), 1);
      matrix = i > 0 ? win(i-1) : '0;
      if (i == drop_at) begin
        pix_valid = 1'b0;
        step();
        break;
      end
      pix_valid = 1'b1;
      w_load = i == wl_at;
      w_data = 8'sd50;
      start = i == st_at;
      step();
    end
    w_load = 1'b0;
    start = 1'b0;
    pix_valid = 1'b0;
    matrix = win(24);
    if (rst_flush) begin
      n_before = got.size();
      reset = 1'b0;
      #2;
      check("rst_result", int'(result), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_done", int'(frame_done), 0);
      step();
      reset = 1'b1;
      repeat (8) step();
      check("rst_no_more_out", got.size(), n_before);
      check("rst_no_done", ndone, 0);
    end else begin
      repeat (8) step();
    end
  endtask

  task automatic check_frame(input int exp [9]);
    check("out_count", got.size(), 9);
    for (int i = 0; i < 9; i++) check($sformatf("result[%0d]", i), i < got.size() ? got[i] : -999999, exp[i]);
    check("done_count", ndone, 1);
    check("done_with_last", done_at, 9);
    check("idle_after", int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", int'(result), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_err", int'(err), 0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 25; i++) img[i] = 1;
    load_w('{default: 1});
    run_frame(-1, -1, -1, 1'b0);
    check_frame('{default: 9});

    for (int i = 0; i < 25; i++) img[i] = i;
    load_w('{0, 0, 0, 0, 0, 0, 0, 0, 1});
    run_frame(-1, -1, -1, 1'b0);
    check_frame('{12, 13, 14, 17, 18, 19, 22, 23, 24});

    for (int i = 0; i < 25; i++) img[i] = 1;
    load_w('{default: -1});
    bias = 16'sd5;
    run_frame(-1, -1, -1, 1'b0);
    check_frame('{default: -4});
    relu_en = 1'b1;
    run_frame(-1, -1, -1, 1'b0);
    check_frame('{default: 0});
    relu_en = 1'b0;

    for (int i = 0; i < 25; i++) img[i] = -256;
    load_w('{default: -128});
    bias = 16'sd32767;
    run_frame(-1, -1, -1, 1'b0);
    check_frame('{default: 327679});

    for (int i = 0; i < 25; i++) img[i] = i;
    load_w('{0, 0, 0, 0, 0, 0, 0, 0, 1});
    bias = 16'sd0;
    run_frame(-1, 7, -1, 1'b0);
    check("wload_run_err", int'(err), 1);
    check_frame('{12, 13, 14, 17, 18, 19, 22, 23, 24});
    run_frame(-1, -1, 5, 1'b0);
    check("start_busy_err", int'(err), 1);
    check_frame('{12, 13, 14, 17, 18, 19, 22, 23, 24});

    run_frame(10, -1, -1, 1'b0);
    check("drop_err", int'(err), 1);
    check("drop_busy", int'(busy), 0);
    check("drop_no_done", ndone, 0);
    check("drop_no_out", got.size(), 0);

    for (int i = 0; i < 25; i++) img[i] = 1;
    load_w('{default: 1});
    run_frame(-1, -1, -1, 1'b1);
    load_w('{default: 1});
    run_frame(-1, -1, -1, 1'b0);
    check_frame('{default: 9});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/conv3x3_window_mac.md
CONV3X3_WINDOW_MAC -- requirements
Module: conv3x3_window_mac

Interface
REQ-001 Parameter IMG_W, 226, padded row width in pixels; equals the upstream line-buffer depth.
REQ-002 Parameter IMG_H, 226, padded frame height in rows.
REQ-003 Parameter DATA_W, 9, signed pixel width; equals the upstream line-buffer element width.
REQ-004 Parameter W_W, 8, signed weight width.
REQ-005 Parameter ACC_W, 21, signed result width (DATA_W+W_W+4).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle pulse; begins a frame when IDLE.
REQ-009 pix_valid  input  1  high in every cycle a pixel is on the line-buffer data input.
REQ-010 matrix  input  9*DATA_W  3x3 window from line buffer; slice [DATA_W*k +: DATA_W], k=0 top-left p(r-2,c-2) .. k=2 p(r-2,c), k=3 p(r-1,c-2) .. k=5 p(r-1,c), k=6 p(r,c-2) .. k=8 newest p(r,c).
REQ-011 w_load  input  1  weight write strobe.
REQ-012 w_data  input  W_W  signed weight; writes 0..8 map to taps k=0..8.
REQ-013 bias  input  16  signed bias, static during a frame.
REQ-014 relu_en  input  1  clamp negative results to 0; static during a frame.
REQ-015 result  output  ACC_W  signed convolution result.
REQ-016 out_valid  output  1  result valid this cycle.
REQ-017 frame_done  output  1  one-cycle pulse with the final result of a frame.
REQ-018 busy  output  1  high in RUN or FLUSH.
REQ-019 err  output  1  sticky protocol error flag.

Function
REQ-020 FSM states IDLE, RUN, FLUSH; IDLE->RUN on start; RUN->FLUSH on capture of pixel IMG_W*IMG_H-1; FLUSH->IDLE after 3 cycles.
REQ-021 In RUN each clock edge with pix_valid high captures one pixel; col/row counters advance with col wrapping IMG_W-1->0 and row incrementing on wrap.
REQ-022 Window valid for captured pixel (r,c) iff r>=2 and c>=2; registered on the capture edge k, aligned with matrix in the following cycle.
REQ-023 Pipeline: edge k+1 registers 9 signed products matrix tap x weight tap (DATA_W+W_W bits); edge k+2 registers the sign-extended sum of products plus bias; edge k+3 registers result with optional ReLU; out_valid at edge k+3 equals the window valid from edge k.
REQ-024 Full-precision arithmetic, no truncation or saturation; ACC_W bits cannot overflow.
REQ-025 Exactly (IMG_W-2)*(IMG_H-2) out_valid pulses per frame, in raster order.
REQ-026 frame_done asserts at the same edge as the result for pixel IMG_W*IMG_H-1; FSM returns to IDLE at that edge.
REQ-027 Weight loading accepted only in IDLE: each w_load writes w_data to tap index then increments index; index wraps 8->0; index resets to 0 on start.
REQ-028 w_load in RUN or FLUSH is ignored and sets err.
REQ-029 pix_valid low in RUN before the last pixel sets err, clears in-flight valids, and returns FSM to IDLE; no frame_done.
REQ-030 start while busy is ignored and sets err; start in IDLE clears err.
REQ-031 pix_valid in IDLE or FLUSH is ignored.

Reset
REQ-032 reset low: FSM IDLE; counters, tap index, pipeline valids 0; result 0; out_valid, frame_done, busy, err 0; weights 0.
REQ-033 reset asserted mid-frame aborts immediately with no further out_valid; the next start behaves as a fresh frame.

Verification
REQ-034 IMG_W=IMG_H=5, all weights 1, bias 0, pixels = 1 -> 9 out_valid pulses, each result 9; frame_done with the 9th.
REQ-035 Same size, weight tap 8 = 1 and others 0, pixels 0..24 raster -> results 12,13,14,17,18,19,22,23,24.
REQ-036 Weights all -1, bias 5, pixels = 1, relu_en 0 -> result -4; relu_en 1 -> result 0.
REQ-037 Extremes: pixels -256, weights -128, bias 32767 -> result 327679, no wrap.
REQ-038 pix_valid dropped at pixel 10 -> err=1, busy=0, no frame_done; w_load during RUN -> err=1 and weights unchanged.
REQ-039 reset pulled low mid-FLUSH -> all outputs 0 next cycle; a new frame then yields 9 correct results.
